// File: rtl/gnr_cycle_ctrl_pkg.sv
// Shared definitions for the gene-regulatory-network cycle controller:
// FSM state encodings and default sizing for the controller and its counters.
package gnr_cycle_ctrl_pkg;

    localparam int DEF_N_NODES   = 8;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_MAX_STEPS = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_STEP  = 3'd2,
        ST_CHK   = 3'd3,
        ST_PSTEP = 3'd4,
        ST_PCHK  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // A meeting is only meaningful once the tortoise has caught up on a whole step.
    function automatic logic isEvenStep(input logic lsb);
        return ~lsb;
    endfunction

endpackage

// File: rtl/gnr_step_cnt.sv
// Saturating step counter with synchronous clear and a terminal-count flag.
// Used for both the meeting-step count k and the period count p.
module gnr_step_cnt #(
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o
);

    localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] OneVal = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over increment; the count holds at the limit so it never wraps.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !at_max_o) begin
            count_d = count_q + OneVal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == MaxVal);

endmodule

// File: rtl/gnr_cycle_ctrl.sv
// Tortoise/hare sequencer for a dual-copy boolean-network node bank: finds the
// step at which the copies meet, then measures the attractor period.
module gnr_cycle_ctrl
    import gnr_cycle_ctrl_pkg::*;
#(
    parameter int N_NODES   = DEF_N_NODES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] cfg_init,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period,
    output logic               timeout
);

    state_e state_q;
    state_e state_d;

    logic [CNT_W-1:0] kCount;
    logic [CNT_W-1:0] pCount;
    logic             kAtMax;
    logic             pAtMax;

    logic jobAccept;
    logic copiesEqual;
    logic chkMeet;
    logic chkTimeout;
    logic pchkMatch;
    logic pchkTimeout;

    logic               reset_nos_q,  reset_nos_d;
    logic [N_NODES-1:0] init_state_q, init_state_d;
    logic               start_s0_q,   start_s0_d;
    logic               start_s1_q,   start_s1_d;
    logic               busy_q,       busy_d;
    logic               done_valid_q, done_valid_d;
    logic [CNT_W-1:0]   meet_q,       meet_d;
    logic [CNT_W-1:0]   period_q,     period_d;
    logic               timeout_q,    timeout_d;

    assign jobAccept   = (state_q == ST_IDLE) && start;
    assign copiesEqual = (s0_vec == s1_vec);
    assign chkMeet     = (state_q == ST_CHK) && isEvenStep(kCount[0]) && copiesEqual;
    assign chkTimeout  = (state_q == ST_CHK) && !chkMeet && kAtMax;
    assign pchkMatch   = (state_q == ST_PCHK) && copiesEqual;
    assign pchkTimeout = (state_q == ST_PCHK) && !pchkMatch && pAtMax;

    gnr_step_cnt #(
        .CNT_W     (CNT_W),
        .MAX_STEPS (MAX_STEPS)
    ) u_kCnt (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (jobAccept),
        .inc_i    (state_q == ST_STEP),
        .count_o  (kCount),
        .at_max_o (kAtMax)
    );

    gnr_step_cnt #(
        .CNT_W     (CNT_W),
        .MAX_STEPS (MAX_STEPS)
    ) u_pCnt (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (jobAccept),
        .inc_i    (state_q == ST_PSTEP),
        .count_o  (pCount),
        .at_max_o (pAtMax)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_INIT;
            ST_INIT:  state_d = ST_STEP;
            ST_STEP:  state_d = ST_CHK;
            ST_CHK: begin
                if (chkMeet) begin
                    state_d = ST_PSTEP;
                end else if (chkTimeout) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_PSTEP: state_d = ST_PCHK;
            ST_PCHK: begin
                if (pchkMatch || pchkTimeout) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PSTEP;
                end
            end
            ST_DONE:  if (done_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear in the cycle the state is entered.
    always_comb begin
        reset_nos_d  = (state_d == ST_INIT);
        start_s0_d   = (state_d == ST_STEP);
        start_s1_d   = (state_d == ST_STEP) || (state_d == ST_PSTEP);
        busy_d       = (state_d != ST_IDLE);
        done_valid_d = (state_d == ST_DONE);
        init_state_d = init_state_q;
        meet_d       = meet_q;
        period_d     = period_q;
        timeout_d    = timeout_q;

        if (jobAccept) begin
            init_state_d = cfg_init;
            meet_d       = '0;
            period_d     = '0;
            timeout_d    = 1'b0;
        end

        if (chkMeet) begin
            meet_d = kCount;
        end else if (chkTimeout) begin
            meet_d    = kCount;
            period_d  = '0;
            timeout_d = 1'b1;
        end

        if (pchkMatch) begin
            period_d = pCount;
        end else if (pchkTimeout) begin
            period_d  = '0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reset_nos_q  <= 1'b0;
            init_state_q <= '0;
            start_s0_q   <= 1'b0;
            start_s1_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b0;
            meet_q       <= '0;
            period_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            reset_nos_q  <= reset_nos_d;
            init_state_q <= init_state_d;
            start_s0_q   <= start_s0_d;
            start_s1_q   <= start_s1_d;
            busy_q       <= busy_d;
            done_valid_q <= done_valid_d;
            meet_q       <= meet_d;
            period_q     <= period_d;
            timeout_q    <= timeout_d;
        end
    end

    assign reset_nos  = reset_nos_q;
    assign init_state = init_state_q;
    assign start_s0   = start_s0_q;
    assign start_s1   = start_s1_q;
    assign busy       = busy_q;
    assign done_valid = done_valid_q;
    assign meet_steps = meet_q;
    assign period     = period_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// Directed bench for gnr_cycle_ctrl with a behavioural two-node bank that
// applies the half-rate rule to the s0 copy.
module tb_gnr_cycle_ctrl;

    localparam int NN = 2;
    localparam int CW = 16;
    localparam int MS = 16;

    typedef struct packed {
        logic [CW-1:0] meet;
        logic [CW-1:0] per;
        logic          to;
    } expT;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NN-1:0] cfg_init;
    logic [NN-1:0] s0_vec;
    logic [NN-1:0] s1_vec;
    logic          reset_nos;
    logic [NN-1:0] init_state;
    logic          start_s0;
    logic          start_s1;
    logic          busy;
    logic          done_valid;
    logic          done_ready;
    logic [CW-1:0] meet_steps;
    logic [CW-1:0] period;
    logic          timeout;

    int  vectors     = 0;
    int  miscompares = 0;
    int  cycCount    = 0;
    int  t0          = 0;
    int  netSel      = 0;
    logic forceInv   = 1'b0;
    expT sbq[$];

    logic [NN-1:0] s0m;
    logic [NN-1:0] s1m;
    logic          halfPhase;

    gnr_cycle_ctrl #(
        .N_NODES   (NN),
        .CNT_W     (CW),
        .MAX_STEPS (MS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_init   (cfg_init),
        .s0_vec     (s0_vec),
        .s1_vec     (s1_vec),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start_s0   (start_s0),
        .start_s1   (start_s1),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .meet_steps (meet_steps),
        .period     (period),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    function automatic logic [NN-1:0] netF(input logic [NN-1:0] x, input int sel);
        return (sel == 1) ? {x[0], x[1]} : x;
    endfunction

    // Node bank: s1 steps on every pulse, s0 only on every second start_s0 pulse.
    always @(posedge clk) begin
        if (rst) begin
            s0m       <= '0;
            s1m       <= '0;
            halfPhase <= 1'b0;
        end else if (reset_nos) begin
            s0m       <= init_state;
            s1m       <= init_state;
            halfPhase <= 1'b0;
        end else begin
            if (start_s1) s1m <= netF(s1m, netSel);
            if (start_s0) begin
                halfPhase <= ~halfPhase;
                if (halfPhase) s0m <= netF(s0m, netSel);
            end
        end
    end

    assign s0_vec = s0m;
    assign s1_vec = forceInv ? ~s0m : s1m;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NN-1:0] init, input int sel, input logic inv,
                                 input int expMeet, input int expPer, input logic expTo);
        expT e;
        netSel   = sel;
        forceInv = inv;
        cfg_init = init;
        start    = 1'b1;
        e.meet   = CW'(expMeet);
        e.per    = CW'(expPer);
        e.to     = expTo;
        sbq.push_back(e);
        t0 = cycCount;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("reset_nos_c1", 32'(reset_nos), 32'd1);
        checkOutput("init_state_c1", 32'(init_state), 32'(init));
        checkOutput("busy_c1", 32'(busy), 32'd1);
    endtask

    task automatic waitDone(input int expCycle);
        expT e;
        int guard = 0;
        while (!done_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("done_valid", 32'(done_valid), 32'd1);
        checkOutput("done_cycle", 32'(cycCount - t0), 32'(expCycle));
        vectors++;
        assert (sbq.size() > 0) else begin
            miscompares++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("meet_steps", 32'(meet_steps), 32'(e.meet));
            checkOutput("period", 32'(period), 32'(e.per));
            checkOutput("timeout", 32'(timeout), 32'(e.to));
        end
    endtask

    task automatic acceptResult();
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checkOutput("done_valid_drop", 32'(done_valid), 32'd0);
        checkOutput("busy_drop", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=hang expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        done_ready = 1'b0;
        cfg_init   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_reset_nos", 32'(reset_nos), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done_valid", 32'(done_valid), 32'd0);
        checkOutput("rst_init_state", 32'(init_state), 32'd0);
        checkOutput("rst_meet", 32'(meet_steps), 32'd0);
        checkOutput("rst_period", 32'(period), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] identity network");
        applyStimulus(2'b01, 0, 1'b0, 2, 1, 1'b0);
        waitDone(8);
        acceptResult();

        $display("[TB] swap network");
        applyStimulus(2'b01, 1, 1'b0, 4, 2, 1'b0);
        waitDone(14);
        acceptResult();

        $display("[TB] forced inequality");
        applyStimulus(2'b01, 0, 1'b1, MS, 0, 1'b1);
        waitDone(2 * MS + 2);
        acceptResult();
        forceInv = 1'b0;

        $display("[TB] backpressure in DONE");
        applyStimulus(2'b10, 0, 1'b0, 2, 1, 1'b0);
        waitDone(8);
        for (int i = 0; i < 5; i++) begin
            start    = (i == 2);
            cfg_init = 2'b11;
            @(negedge clk);
            checkOutput("hold_done_valid", 32'(done_valid), 32'd1);
            checkOutput("hold_meet", 32'(meet_steps), 32'd2);
            checkOutput("hold_period", 32'(period), 32'd1);
            checkOutput("hold_reset_nos", 32'(reset_nos), 32'd0);
            checkOutput("hold_init_state", 32'(init_state), 32'd2);
        end
        start = 1'b0;
        acceptResult();
        applyStimulus(2'b11, 0, 1'b0, 2, 1, 1'b0);
        waitDone(8);
        acceptResult();

        $display("[TB] reset during PSTEP");
        applyStimulus(2'b01, 1, 1'b0, 4, 2, 1'b0);
        repeat (9) @(negedge clk);
        checkOutput("pstep_s1", 32'(start_s1), 32'd1);
        checkOutput("pstep_s0", 32'(start_s0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sbq.pop_back());
        checkOutput("mid_reset_nos", 32'(reset_nos), 32'd0);
        checkOutput("mid_s0", 32'(start_s0), 32'd0);
        checkOutput("mid_s1", 32'(start_s1), 32'd0);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_done_valid", 32'(done_valid), 32'd0);
        checkOutput("mid_init_state", 32'(init_state), 32'd0);
        checkOutput("mid_meet", 32'(meet_steps), 32'd0);
        checkOutput("mid_period", 32'(period), 32'd0);
        checkOutput("mid_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        checkOutput("post_rst_s1", 32'(start_s1), 32'd0);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        applyStimulus(2'b01, 1, 1'b0, 4, 2, 1'b0);
        waitDone(14);
        acceptResult();

        $display("[TB] start while busy");
        applyStimulus(2'b01, 0, 1'b0, 2, 1, 1'b0);
        @(negedge clk);
        start    = 1'b1;
        cfg_init = 2'b10;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_init_state", 32'(init_state), 32'd1);
        checkOutput("busy_reset_nos", 32'(reset_nos), 32'd0);
        waitDone(8);
        acceptResult();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
